// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_stage
//  Description : N-wide fetch stage with a circular fetch queue between the
//                icache and dispatch. Enqueues the in-order prefix of icache
//                hits (limited by free slots), dequeues a variable count for
//                dispatch, and flushes/restarts on redirect.
//                Lane FETCH_W-1 is the oldest (lowest PC) lane everywhere.
//                if_packet_out lane i = bits [i*PKT_W +: PKT_W], laid out as
//                {valid, inst[31:0], PC[XLEN-1:0], NPC[XLEN-1:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
  parameter int              FETCH_W  = 3,
  parameter int              QDEPTH   = 8,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               redirect_en,
  input  logic [XLEN-1:0]                    redirect_pc,
  input  logic [FETCH_W*32-1:0]              cache_data,
  input  logic [FETCH_W-1:0]                 cache_valid,
  input  logic [$clog2(FETCH_W+1)-1:0]       dis_take,
  output logic [FETCH_W*XLEN-1:0]            proc2Icache_addr,
  output logic [FETCH_W*(1+32+2*XLEN)-1:0]   if_packet_out,
  output logic [$clog2(FETCH_W+1)-1:0]       if_count,
  output logic [FETCH_W-1:0]                 fetch_EN,
  output logic [FETCH_W*XLEN-1:0]            fetch_pc,
  output logic                               fetch_full
);

  localparam int c_PTR_W  = $clog2(QDEPTH);
  localparam int c_CNT_W  = $clog2(QDEPTH+1);
  localparam int c_TAKE_W = $clog2(FETCH_W+1);
  localparam int c_PKT_W  = 1 + 32 + 2*XLEN;
  localparam logic [c_CNT_W-1:0] c_QDEPTH = c_CNT_W'(QDEPTH);

  // Registered state
  logic [XLEN-1:0]    r_fetch_pc;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic [XLEN-1:0]    r_mem_pc   [QDEPTH];
  logic [31:0]        r_mem_inst [QDEPTH];

  // Combinational helpers; w_wr_* are indexed by age (0 = oldest lane)
  logic [XLEN-1:0]     w_lane_pc [FETCH_W];
  logic [c_CNT_W-1:0]  w_hits;
  logic                w_run;
  logic [c_CNT_W-1:0]  w_free;
  logic [c_CNT_W-1:0]  w_k;
  logic [c_TAKE_W-1:0] w_if_count;
  logic [c_TAKE_W-1:0] w_d;
  logic [FETCH_W-1:0]  w_wr_en;
  logic [c_PTR_W-1:0]  w_wr_idx [FETCH_W];
  logic [c_PTR_W-1:0]  w_rd_idx;
  logic                w_unused_pc_lsbs;

  // The two low redirect bits are forced to zero and never consumed
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  // Per-lane request address; the same address feeds the branch predictor
  generate
    for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
      assign w_lane_pc[i]                       = r_fetch_pc + XLEN'(4*(FETCH_W-1-i));
      assign proc2Icache_addr[i*XLEN +: XLEN]   = w_lane_pc[i];
      assign fetch_pc[i*XLEN +: XLEN]           = w_lane_pc[i];
      assign fetch_EN[i]                        = w_wr_en[FETCH_W-1-i];
    end
  endgenerate

  // Length of the consecutive hit run starting at the oldest lane
  always_comb begin
    w_hits = '0;
    w_run  = 1'b1;
    for (int j = 0; j < FETCH_W; j++) begin
      if (w_run && cache_valid[FETCH_W-1-j]) begin
        w_hits = w_hits + c_CNT_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Enqueue count uses pre-dequeue occupancy; redirect suppresses both sides
  assign w_free     = c_QDEPTH - r_count;
  assign w_k        = redirect_en ? '0 : ((w_hits < w_free) ? w_hits : w_free);
  assign w_if_count = (r_count < c_CNT_W'(FETCH_W)) ? c_TAKE_W'(r_count)
                                                    : c_TAKE_W'(FETCH_W);
  assign w_d        = redirect_en ? '0 : ((dis_take < w_if_count) ? dis_take : w_if_count);

  // Write enables and slot indices for the k oldest lanes
  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      w_wr_en[j]  = (c_CNT_W'(j) < w_k);
      w_wr_idx[j] = r_tail + c_PTR_W'(j);
    end
  end

  // Pointer, occupancy and fetch PC update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect_en) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= r_fetch_pc + (XLEN'(w_k) << 2);
      r_tail     <= r_tail + c_PTR_W'(w_k);
      r_head     <= r_head + c_PTR_W'(w_d);
      r_count    <= r_count + w_k - c_CNT_W'(w_d);
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clock) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (w_wr_en[j]) begin
        r_mem_pc[w_wr_idx[j]]   <= w_lane_pc[FETCH_W-1-j];
        r_mem_inst[w_wr_idx[j]] <= cache_data[(FETCH_W-1-j)*32 +: 32];
      end
    end
  end

  // Present the queue head, oldest entry on the highest lane, zeros elsewhere
  always_comb begin
    if_packet_out = '0;
    w_rd_idx      = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      if (c_TAKE_W'(j) < w_if_count) begin
        w_rd_idx = r_head + c_PTR_W'(j);
        if_packet_out[(FETCH_W-1-j)*c_PKT_W +: c_PKT_W] =
          {1'b1, r_mem_inst[w_rd_idx], r_mem_pc[w_rd_idx], r_mem_pc[w_rd_idx] + XLEN'(4)};
      end
    end
  end

  assign if_count   = w_if_count;
  assign fetch_full = (r_count == c_QDEPTH);

endmodule
`default_nettype wire
